// File: rtl/imuldiv_div_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : imuldiv_div_arbiter
// Brief    : Round-robin sharing of one non-pipelined divider between two
//            requester ports, with per-port grant counters.
// Revision : 1.0 - initial release
// ============================================================================
module imuldiv_div_arbiter #(
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              reset,

  input  logic              req0_msg_fn,
  input  logic [31:0]       req0_msg_a,
  input  logic [31:0]       req0_msg_b,
  input  logic              req0_val,
  output logic              req0_rdy,
  output logic [63:0]       resp0_msg_result,
  output logic              resp0_val,
  input  logic              resp0_rdy,

  input  logic              req1_msg_fn,
  input  logic [31:0]       req1_msg_a,
  input  logic [31:0]       req1_msg_b,
  input  logic              req1_val,
  output logic              req1_rdy,
  output logic [63:0]       resp1_msg_result,
  output logic              resp1_val,
  input  logic              resp1_rdy,

  output logic              divreq_msg_fn,
  output logic [31:0]       divreq_msg_a,
  output logic [31:0]       divreq_msg_b,
  output logic              divreq_val,
  input  logic              divreq_rdy,
  input  logic [63:0]       divresp_msg_result,
  input  logic              divresp_val,
  output logic              divresp_rdy,

  output logic [CNT_W-1:0]  grant_cnt0,
  output logic [CNT_W-1:0]  grant_cnt1
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] C_CNT_ONE = 1;

  state_t           r_state;
  logic             r_owner;
  logic             r_prio;
  logic [CNT_W-1:0] r_grant_cnt0;
  logic [CNT_W-1:0] r_grant_cnt1;

  logic w_idle;
  logic w_any_req;
  logic w_winner;
  logic w_issue;
  logic w_owner_resp_rdy;
  logic w_resp_done;

  assign w_idle    = (r_state == ST_IDLE);
  assign w_any_req = req0_val | req1_val;

  // On a tie the favoured port wins; otherwise whichever port is requesting.
  assign w_winner  = (req0_val & req1_val) ? r_prio : req1_val;

  assign divreq_val    = w_idle & w_any_req;
  assign divreq_msg_fn = w_winner ? req1_msg_fn : req0_msg_fn;
  assign divreq_msg_a  = w_winner ? req1_msg_a  : req0_msg_a;
  assign divreq_msg_b  = w_winner ? req1_msg_b  : req0_msg_b;

  assign req0_rdy = w_idle & req0_val & ~w_winner & divreq_rdy;
  assign req1_rdy = w_idle & req1_val &  w_winner & divreq_rdy;
  assign w_issue  = divreq_val & divreq_rdy;

  assign resp0_msg_result = divresp_msg_result;
  assign resp1_msg_result = divresp_msg_result;
  assign resp0_val        = ~w_idle & ~r_owner & divresp_val;
  assign resp1_val        = ~w_idle &  r_owner & divresp_val;

  assign w_owner_resp_rdy = r_owner ? resp1_rdy : resp0_rdy;
  assign divresp_rdy      = ~w_idle & w_owner_resp_rdy;
  assign w_resp_done      = ~w_idle & divresp_val & w_owner_resp_rdy;

  assign grant_cnt0 = r_grant_cnt0;
  assign grant_cnt1 = r_grant_cnt1;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state      <= ST_IDLE;
      r_owner      <= 1'b0;
      r_prio       <= 1'b0;
      r_grant_cnt0 <= '0;
      r_grant_cnt1 <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_issue) begin
            r_owner <= w_winner;
            r_prio  <= ~w_winner;
            r_state <= ST_BUSY;
            if (w_winner) r_grant_cnt1 <= r_grant_cnt1 + C_CNT_ONE;
            else          r_grant_cnt0 <= r_grant_cnt0 + C_CNT_ONE;
          end
        end
        ST_BUSY: begin
          if (w_resp_done) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_imuldiv_div_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_imuldiv_div_arbiter
// Brief    : Directed and random checks of the divider arbiter against a
//            transaction-level model with a behavioural divider.
// Revision : 1.0 - initial release
// ============================================================================
module tb_imuldiv_div_arbiter;

  localparam logic FN_SIGNED   = 1'b0;
  localparam logic FN_UNSIGNED = 1'b1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        req0_msg_fn, req1_msg_fn;
  logic [31:0] req0_msg_a, req0_msg_b, req1_msg_a, req1_msg_b;
  logic        req0_val, req1_val, resp0_rdy, resp1_rdy;
  logic        divreq_rdy, divresp_val;
  logic [63:0] divresp_msg_result;

  logic        req0_rdy, req1_rdy, resp0_val, resp1_val;
  logic [63:0] resp0_msg_result, resp1_msg_result;
  logic        divreq_msg_fn, divreq_val, divresp_rdy;
  logic [31:0] divreq_msg_a, divreq_msg_b;
  logic [15:0] grant_cnt0, grant_cnt1;

  logic        w2_req0_rdy, w2_req1_rdy, w2_resp0_val, w2_resp1_val;
  logic [63:0] w2_resp0_msg_result, w2_resp1_msg_result;
  logic        w2_divreq_msg_fn, w2_divreq_val, w2_divresp_rdy;
  logic [31:0] w2_divreq_msg_a, w2_divreq_msg_b;
  logic [1:0]  w2_grant_cnt0, w2_grant_cnt1;

  imuldiv_div_arbiter #(.CNT_W(16)) u_dut (
    .clk(clk), .reset(reset),
    .req0_msg_fn(req0_msg_fn), .req0_msg_a(req0_msg_a), .req0_msg_b(req0_msg_b),
    .req0_val(req0_val), .req0_rdy(req0_rdy),
    .resp0_msg_result(resp0_msg_result), .resp0_val(resp0_val), .resp0_rdy(resp0_rdy),
    .req1_msg_fn(req1_msg_fn), .req1_msg_a(req1_msg_a), .req1_msg_b(req1_msg_b),
    .req1_val(req1_val), .req1_rdy(req1_rdy),
    .resp1_msg_result(resp1_msg_result), .resp1_val(resp1_val), .resp1_rdy(resp1_rdy),
    .divreq_msg_fn(divreq_msg_fn), .divreq_msg_a(divreq_msg_a), .divreq_msg_b(divreq_msg_b),
    .divreq_val(divreq_val), .divreq_rdy(divreq_rdy),
    .divresp_msg_result(divresp_msg_result), .divresp_val(divresp_val), .divresp_rdy(divresp_rdy),
    .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1)
  );

  // Narrow-counter copy driven by identical stimulus, for the wrap behaviour.
  imuldiv_div_arbiter #(.CNT_W(2)) u_dut_wrap (
    .clk(clk), .reset(reset),
    .req0_msg_fn(req0_msg_fn), .req0_msg_a(req0_msg_a), .req0_msg_b(req0_msg_b),
    .req0_val(req0_val), .req0_rdy(w2_req0_rdy),
    .resp0_msg_result(w2_resp0_msg_result), .resp0_val(w2_resp0_val), .resp0_rdy(resp0_rdy),
    .req1_msg_fn(req1_msg_fn), .req1_msg_a(req1_msg_a), .req1_msg_b(req1_msg_b),
    .req1_val(req1_val), .req1_rdy(w2_req1_rdy),
    .resp1_msg_result(w2_resp1_msg_result), .resp1_val(w2_resp1_val), .resp1_rdy(resp1_rdy),
    .divreq_msg_fn(w2_divreq_msg_fn), .divreq_msg_a(w2_divreq_msg_a), .divreq_msg_b(w2_divreq_msg_b),
    .divreq_val(w2_divreq_val), .divreq_rdy(divreq_rdy),
    .divresp_msg_result(divresp_msg_result), .divresp_val(divresp_val), .divresp_rdy(w2_divresp_rdy),
    .grant_cnt0(w2_grant_cnt0), .grant_cnt1(w2_grant_cnt1)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Transaction-level model of the arbiter and environment divider state.
  logic        m_known = 1'b0;
  logic        m_busy, m_owner, m_prio;
  logic [15:0] m_cnt0, m_cnt1;
  logic [63:0] m_exp;
  logic        dv_busy;
  int          dv_cnt;
  logic [63:0] dv_res;
  int          m_lat = 1;
  int          issue_cnt = 0;
  int          issue_port_q[$];
  int          issue_cyc_q[$];
  int          resp_done_cyc;
  logic [63:0] last_resp0, last_resp1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] div_ref(input logic fn, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] q, r;
    if (fn == FN_SIGNED) begin
      q = $signed(a) / $signed(b);
      r = $signed(a) % $signed(b);
    end else begin
      q = a / b;
      r = a % b;
    end
    return {r, q};
  endfunction

  function automatic logic [31:0] rand_b(input logic [31:0] a);
    logic [31:0] b;
    b = $urandom_range(1, 1000);
    if ($urandom_range(0, 1) == 1) b = -b;
    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) b = 32'd3;
    return b;
  endfunction

  task automatic tick();
    logic        w, f_issue, f_resp, o_rdy;
    logic        c_fn, d_fn;
    logic [31:0] c_a, c_b, d_a, d_b;
    logic [63:0] r_data;
    f_issue = 1'b0;
    f_resp  = 1'b0;
    w       = 1'b0;
    @(negedge clk);
    cyc++;
    w    = (req0_val && req1_val) ? m_prio : req1_val;
    c_fn = w ? req1_msg_fn : req0_msg_fn;
    c_a  = w ? req1_msg_a  : req0_msg_a;
    c_b  = w ? req1_msg_b  : req0_msg_b;
    d_fn = divreq_msg_fn; d_a = divreq_msg_a; d_b = divreq_msg_b;
    if (m_known) begin
      chk("grant_cnt0", grant_cnt0, m_cnt0);
      chk("grant_cnt1", grant_cnt1, m_cnt1);
      chk("wrap_cnt0", w2_grant_cnt0, m_cnt0[1:0]);
      chk("wrap_cnt1", w2_grant_cnt1, m_cnt1[1:0]);
      if (!m_busy) begin
        chk("idle_divreq_val", divreq_val, req0_val | req1_val);
        chk("idle_resp0_val", resp0_val, 0);
        chk("idle_resp1_val", resp1_val, 0);
        chk("idle_divresp_rdy", divresp_rdy, 0);
        if (req0_val || req1_val) begin
          chk("divreq_fn", divreq_msg_fn, c_fn);
          chk("divreq_a", divreq_msg_a, c_a);
          chk("divreq_b", divreq_msg_b, c_b);
          chk("req0_rdy", req0_rdy, (w == 1'b0) ? divreq_rdy : 1'b0);
          chk("req1_rdy", req1_rdy, (w == 1'b1) ? divreq_rdy : 1'b0);
        end
        f_issue = (req0_val || req1_val) && divreq_rdy && reset;
      end else begin
        o_rdy = m_owner ? resp1_rdy : resp0_rdy;
        chk("busy_req0_rdy", req0_rdy, 0);
        chk("busy_req1_rdy", req1_rdy, 0);
        chk("busy_divreq_val", divreq_val, 0);
        chk("busy_resp0_val", resp0_val, (m_owner == 1'b0) ? divresp_val : 1'b0);
        chk("busy_resp1_val", resp1_val, (m_owner == 1'b1) ? divresp_val : 1'b0);
        chk("busy_divresp_rdy", divresp_rdy, o_rdy);
        if (divresp_val) begin
          r_data = m_owner ? resp1_msg_result : resp0_msg_result;
          chk("resp_result", r_data, m_exp);
        end
        f_resp = divresp_val && o_rdy && reset;
      end
    end
    @(posedge clk);
    if (!reset) begin
      m_known = 1'b1;
      m_busy = 1'b0; m_owner = 1'b0; m_prio = 1'b0;
      m_cnt0 = '0; m_cnt1 = '0;
      dv_busy = 1'b0; dv_cnt = 0;
    end else if (m_known) begin
      if (f_issue) begin
        m_busy = 1'b1; m_owner = w; m_prio = ~w;
        if (w) m_cnt1++; else m_cnt0++;
        m_exp = div_ref(c_fn, c_a, c_b);
        issue_cnt++;
        issue_port_q.push_back(int'(w));
        issue_cyc_q.push_back(cyc);
        dv_busy = 1'b1; dv_cnt = m_lat;
        dv_res  = div_ref(d_fn, d_a, d_b);
      end else if (f_resp) begin
        m_busy = 1'b0; dv_busy = 1'b0;
        resp_done_cyc = cyc;
        if (m_owner) last_resp1 = m_exp; else last_resp0 = m_exp;
      end else if (dv_busy && dv_cnt > 0) begin
        dv_cnt--;
      end
    end
    #1;
    divreq_rdy         = ~dv_busy;
    divresp_val        = dv_busy && (dv_cnt == 0);
    divresp_msg_result = divresp_val ? dv_res : {$urandom, $urandom};
  endtask

  task automatic run_until_issues(input int n, input int limit);
    int start;
    start = issue_cnt;
    for (int i = 0; i < limit && issue_cnt < start + n; i++) tick();
    chk("issue_timeout", issue_cnt - start >= n, 1);
  endtask

  task automatic run_until_idle(input int limit);
    for (int i = 0; i < limit && m_busy; i++) tick();
    chk("idle_timeout", m_busy, 0);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick(); tick();
    reset = 1'b1;
  endtask

  initial begin
    int base;
    reset = 1'b0;
    req0_val = 0; req1_val = 0; resp0_rdy = 1; resp1_rdy = 1;
    req0_msg_fn = FN_SIGNED; req0_msg_a = 100; req0_msg_b = 7;
    req1_msg_fn = FN_SIGNED; req1_msg_a = 1;   req1_msg_b = 1;
    dv_busy = 1'b0; dv_cnt = 0; dv_res = '0;
    divreq_rdy = 1'b1; divresp_val = 1'b0; divresp_msg_result = '0;
    last_resp0 = '0; last_resp1 = '0; resp_done_cyc = 0;

    // Reset with port 0 already requesting: it issues right after release.
    req0_val = 1'b1;
    do_reset();
    tick();
    chk("rst_first_issue_cnt", issue_cnt, 1);
    chk("rst_first_issue_port", issue_port_q[$], 0);
    req0_val = 1'b0;
    run_until_idle(20);
    chk("rst_first_result", last_resp0, {32'd2, 32'd14});

    // Single port 1 signed request.
    req1_msg_fn = FN_SIGNED; req1_msg_a = 32'hFFFF_FFF9; req1_msg_b = 32'd2; req1_val = 1'b1;
    run_until_issues(1, 20);
    req1_val = 1'b0;
    run_until_idle(20);
    chk("signed_result", last_resp1, 64'hFFFF_FFFF_FFFF_FFFD);
    chk("signed_cnt1", grant_cnt1, 1);

    // Both ports requesting continuously: strict alternation.
    do_reset();
    req0_msg_fn = FN_SIGNED;   req0_msg_a = 100;          req0_msg_b = 7;
    req1_msg_fn = FN_UNSIGNED; req1_msg_a = 32'h8000_0000; req1_msg_b = 3;
    req0_val = 1'b1; req1_val = 1'b1;
    base = issue_port_q.size();
    run_until_issues(4, 80);
    req0_val = 1'b0; req1_val = 1'b0;
    run_until_idle(20);
    for (int i = 0; i < 4; i++) chk("tie_order", issue_port_q[base + i], i % 2);
    chk("tie_result0", last_resp0, {32'd2, 32'd14});
    chk("tie_result1", last_resp1, {32'd2, 32'h2AAA_AAAA});
    chk("tie_cnt0", grant_cnt0, 2);
    chk("tie_cnt1", grant_cnt1, 2);

    // Response back-pressure on port 0 while port 1 waits.
    do_reset();
    req0_msg_a = 50; req0_msg_b = 5; req1_msg_a = 9; req1_msg_b = 4;
    resp0_rdy = 1'b0; req0_val = 1'b1;
    run_until_issues(1, 20);
    req0_val = 1'b0; req1_val = 1'b1;
    base = issue_cnt;
    for (int i = 0; i < 20 && !divresp_val; i++) tick();
    chk("bp_resp_seen", divresp_val, 1);
    repeat (5) tick();
    chk("bp_no_issue", issue_cnt, base);
    resp0_rdy = 1'b1;
    tick();
    chk("bp_completed", m_busy, 0);
    tick();
    chk("bp_next_port", issue_port_q[$], 1);
    chk("bp_next_cycle", issue_cyc_q[$], resp_done_cyc + 1);
    req1_val = 1'b0;
    run_until_idle(20);

    // Reset in the middle of an operation drops it silently.
    m_lat = 6;
    req0_val = 1'b1;
    run_until_issues(1, 20);
    req0_val = 1'b0;
    tick(); tick();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    repeat (10) tick();
    chk("midrst_cnt0", grant_cnt0, 0);
    m_lat = 1;
    req0_val = 1'b1; req1_val = 1'b1;
    run_until_issues(1, 20);
    chk("midrst_prio_port", issue_port_q[$], 0);
    req0_val = 1'b0; req1_val = 1'b0;
    run_until_idle(20);

    // Counter wrap on the narrow instance.
    do_reset();
    m_lat = 0;
    for (int i = 0; i < 5; i++) begin
      req0_val = 1'b1;
      run_until_issues(1, 20);
      req0_val = 1'b0;
      run_until_idle(20);
    end
    chk("wrap_final", w2_grant_cnt0, 2'd1);
    chk("wide_final", grant_cnt0, 5);

    // Random traffic, random latency and response back-pressure.
    for (int i = 0; i < 400; i++) begin
      m_lat = $urandom_range(0, 3);
      req0_val = ($urandom_range(0, 9) < 6);
      req1_val = ($urandom_range(0, 9) < 6);
      req0_msg_fn = $urandom_range(0, 1); req0_msg_a = $urandom; req0_msg_b = rand_b(req0_msg_a);
      req1_msg_fn = $urandom_range(0, 1); req1_msg_a = $urandom; req1_msg_b = rand_b(req1_msg_a);
      resp0_rdy = ($urandom_range(0, 9) < 7);
      resp1_rdy = ($urandom_range(0, 9) < 7);
      tick();
    end
    req0_val = 1'b0; req1_val = 1'b0; resp0_rdy = 1'b1; resp1_rdy = 1'b1;
    run_until_idle(20);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
